// File: rtl/csr_spmv_pkg.sv
// Shared types and arithmetic helpers for the CSR sparse-matrix x dense-vector engine.
package csr_spmv_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_RP0, S_RP0W, S_RS, S_RSW, S_NI, S_NV, S_NM, S_ROUT, S_DONE
  } state_t;

  // Working width for the accumulate; ACC_W and 2*DATA_W must both stay below it.
  localparam int MAX_W = 128;
  typedef logic signed [MAX_W-1:0] wide_t;

  function automatic wide_t sat_max(input int acc_w);
    return (wide_t'(1) <<< (acc_w - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t sat_min(input int acc_w);
    return ~sat_max(acc_w);
  endfunction

  function automatic wide_t sat_add(input wide_t acc, input wide_t prod,
                                    input logic sat_en, input int acc_w);
    wide_t sum;
    sum = acc + prod;
    if (sat_en) begin
      if (sum > sat_max(acc_w)) sum = sat_max(acc_w);
      else if (sum < sat_min(acc_w)) sum = sat_min(acc_w);
    end
    return sum;
  endfunction

endpackage

// File: rtl/csr_spmv_engine_if.sv
// Memory read ports and result stream of the CSR SpMV engine.
interface csr_spmv_engine_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ACC_W  = 64,
  parameter int ROW_W  = 16
);
  logic [ADDR_W-1:0] a_addr;
  logic              a_rd;
  logic [DATA_W-1:0] a_data;
  logic [ADDR_W-1:0] b_addr;
  logic              b_rd;
  logic [DATA_W-1:0] b_data;
  logic              y_valid;
  logic              y_ready;
  logic [ROW_W-1:0]  y_row;
  logic [ACC_W-1:0]  y_data;

  modport master (
    output a_addr, a_rd, b_addr, b_rd, y_valid, y_row, y_data,
    input  a_data, b_data, y_ready
  );

  modport slave (
    input  a_addr, a_rd, b_addr, b_rd, y_valid, y_row, y_data,
    output a_data, b_data, y_ready
  );
endinterface

// File: rtl/csr_mac.sv
// Signed multiply-accumulate with optional saturation; clear has priority over en.
module csr_mac
  import csr_spmv_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 64,
  parameter int SAT_EN = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;
  wide_t acc_x, prod_x, sum;

  assign prod   = a * b;
  assign prod_x = {{(MAX_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign acc_x  = {{(MAX_W - ACC_W){acc[ACC_W-1]}}, acc};
  // Saturation sees the full-precision sum so an oversized product still clamps.
  assign sum    = sat_add(acc_x, prod_x, SAT_EN != 0, ACC_W);

  // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        acc <= '0;
    else if (clear) acc <= '0;
    else if (en)    acc <= sum[ACC_W-1:0];
  end

endmodule

// File: rtl/csr_spmv_engine.sv
// CSR SpMV engine: walks row pointers, gathers nonzeros and streams one dot product per row.
module csr_spmv_engine
  import csr_spmv_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ACC_W  = 64,
  parameter int SAT_EN = 0,
  parameter int ROW_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ROW_W-1:0]  num_rows,
  input  logic [ADDR_W-1:0] row_base,
  input  logic [ADDR_W-1:0] col_base,
  input  logic [ADDR_W-1:0] mat_base,
  input  logic [ADDR_W-1:0] vec_base,
  output logic              busy,
  output logic              done,
  output logic              err,
  csr_spmv_engine_if.master bus
);

  state_t state, state_nx;
  logic [ROW_W-1:0]  n_rows, r;
  logic [ADDR_W-1:0] row_base_q, col_base_q, mat_base_q, vec_base_q;
  logic [DATA_W-1:0] lo, hi, k, m;
  logic              err_q, zero_done;
  logic signed [ACC_W-1:0] acc;

  logic              a_rd, b_rd;
  logic [ADDR_W-1:0] a_addr, b_addr;

  // NOTE: every combinational output is defaulted first so no path can infer a latch.
  always_comb begin
    state_nx = state;
    a_rd     = 1'b0;
    a_addr   = '0;
    b_rd     = 1'b0;
    b_addr   = '0;
    case (state)
      S_IDLE: if (start && num_rows != '0) state_nx = S_RP0;
      S_RP0: begin
        a_rd     = 1'b1;
        a_addr   = row_base_q;
        state_nx = S_RP0W;
      end
      S_RP0W: state_nx = S_RS;
      S_RS: begin
        a_rd     = 1'b1;
        a_addr   = row_base_q + ADDR_W'(r) + ADDR_W'(1);
        state_nx = S_RSW;
      end
      S_RSW: begin
        if (bus.a_data < lo)       state_nx = S_DONE;
        else if (bus.a_data == lo) state_nx = S_ROUT;
        else                       state_nx = S_NI;
      end
      S_NI: begin
        a_rd     = 1'b1;
        a_addr   = col_base_q + ADDR_W'(k);
        b_rd     = 1'b1;
        b_addr   = mat_base_q + ADDR_W'(k);
        state_nx = S_NV;
      end
      S_NV: begin
        b_rd     = 1'b1;
        b_addr   = vec_base_q + ADDR_W'(bus.a_data);
        state_nx = S_NM;
      end
      S_NM:   state_nx = (k + DATA_W'(1) == hi) ? S_ROUT : S_NI;
      S_ROUT: if (bus.y_ready) state_nx = (r + ROW_W'(1) == n_rows) ? S_DONE : S_RS;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: all state lives in flops (no memory arrays), so every register takes the reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      n_rows     <= '0;
      r          <= '0;
      row_base_q <= '0;
      col_base_q <= '0;
      mat_base_q <= '0;
      vec_base_q <= '0;
      lo         <= '0;
      hi         <= '0;
      k          <= '0;
      m          <= '0;
      err_q      <= 1'b0;
      zero_done  <= 1'b0;
    end else begin
      state     <= state_nx;
      // An empty job pulses done without leaving IDLE.
      zero_done <= (state == S_IDLE) && start && (num_rows == '0);
      case (state)
        S_IDLE: if (start) begin
          n_rows     <= num_rows;
          row_base_q <= row_base;
          col_base_q <= col_base;
          mat_base_q <= mat_base;
          vec_base_q <= vec_base;
          r          <= '0;
          err_q      <= 1'b0;
        end
        S_RP0W: lo <= bus.a_data;
        S_RSW: begin
          hi <= bus.a_data;
          k  <= lo;
          if (bus.a_data < lo) err_q <= 1'b1;
        end
        S_NV:   m <= bus.b_data;
        S_NM:   k <= k + DATA_W'(1);
        S_ROUT: if (bus.y_ready) begin
          lo <= hi;
          r  <= r + ROW_W'(1);
        end
        default: ;
      endcase
    end
  end

  csr_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SAT_EN(SAT_EN)) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clear (state == S_RSW),
    .en    (state == S_NM),
    .a     (m),
    .b     (bus.b_data),
    .acc   (acc)
  );

  assign bus.a_rd    = a_rd;
  assign bus.a_addr  = a_addr;
  assign bus.b_rd    = b_rd;
  assign bus.b_addr  = b_addr;
  assign bus.y_valid = (state == S_ROUT);
  assign bus.y_row   = r;
  assign bus.y_data  = acc;
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE) || zero_done;
  assign err         = err_q;

endmodule

// File: tb/tb_csr_spmv_engine.sv
// Self-checking bench for csr_spmv_engine: table-driven jobs with a result scoreboard.
module tb_csr_spmv_engine;

  typedef struct packed {
    logic [15:0]       n_rows;
    logic [0:3][31:0]  rp, cols, vals, xv;
    logic              stall, exp_err;
    logic [0:2][63:0]  exp_y;
    logic [7:0]        exp_a, exp_b;
  } vec_t;

  typedef struct packed {
    logic [15:0] row;
    logic [63:0] data;
  } exp_t;

  localparam int NCASES  = 7;
  localparam int SAT_IDX = 3;

  logic clk = 1'b0;
  logic rst, start, cnt_clr;
  logic [15:0] num_rows;
  logic [31:0] row_base = 32'h10, col_base = 32'h40, mat_base = 32'h10, vec_base = 32'h80;
  logic busy, done, err;
  logic s_busy, s_done, s_err, w_busy, w_done, w_err;

  logic [31:0] a_mem [256];
  logic [31:0] b_mem [256];
  int n_a, n_b;
  int n_checks = 0, n_fail = 0;
  exp_t sb[$];
  vec_t cases [NCASES];
  logic [31:0] last_sat, last_wrap;

  always #5 clk = ~clk;

  csr_spmv_engine_if #(.ADDR_W(32), .DATA_W(32), .ACC_W(64), .ROW_W(16)) bus ();
  csr_spmv_engine_if #(.ADDR_W(32), .DATA_W(32), .ACC_W(32), .ROW_W(16)) sat_bus ();
  csr_spmv_engine_if #(.ADDR_W(32), .DATA_W(32), .ACC_W(32), .ROW_W(16)) wrap_bus ();

  csr_spmv_engine #(.DATA_W(32), .ADDR_W(32), .ACC_W(64), .SAT_EN(0), .ROW_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
    .row_base(row_base), .col_base(col_base), .mat_base(mat_base), .vec_base(vec_base),
    .busy(busy), .done(done), .err(err), .bus(bus)
  );

  // Narrow-accumulator twins see the same memory data and handshake as the main DUT.
  csr_spmv_engine #(.DATA_W(32), .ADDR_W(32), .ACC_W(32), .SAT_EN(1), .ROW_W(16)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
    .row_base(row_base), .col_base(col_base), .mat_base(mat_base), .vec_base(vec_base),
    .busy(s_busy), .done(s_done), .err(s_err), .bus(sat_bus)
  );

  csr_spmv_engine #(.DATA_W(32), .ADDR_W(32), .ACC_W(32), .SAT_EN(0), .ROW_W(16)) dut_wrap (
    .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
    .row_base(row_base), .col_base(col_base), .mat_base(mat_base), .vec_base(vec_base),
    .busy(w_busy), .done(w_done), .err(w_err), .bus(wrap_bus)
  );

  assign sat_bus.a_data   = bus.a_data;
  assign sat_bus.b_data   = bus.b_data;
  assign sat_bus.y_ready  = bus.y_ready;
  assign wrap_bus.a_data  = bus.a_data;
  assign wrap_bus.b_data  = bus.b_data;
  assign wrap_bus.y_ready = bus.y_ready;

  always @(posedge clk) begin
    if (bus.a_rd) bus.a_data <= a_mem[bus.a_addr[7:0]];
    if (bus.b_rd) bus.b_data <= b_mem[bus.b_addr[7:0]];
  end

  always @(posedge clk) begin
    if (cnt_clr) begin
      n_a <= 0;
      n_b <= 0;
    end else begin
      n_a <= n_a + int'(bus.a_rd);
      n_b <= n_b + int'(bus.b_rd);
    end
  end

  function automatic logic [0:3][31:0] w4(input int a, input int b, input int c, input int d);
    return {32'(a), 32'(b), 32'(c), 32'(d)};
  endfunction

  function automatic logic [0:2][63:0] y3(input longint a, input longint b, input longint c);
    return {64'(a), 64'(b), 64'(c)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic load_mem(input vec_t v);
    for (int i = 0; i < 4; i++) begin
      a_mem[8'h10 + i] = v.rp[i];
      a_mem[8'h40 + i] = v.cols[i];
      b_mem[8'h10 + i] = v.vals[i];
      b_mem[8'h80 + i] = v.xv[i];
    end
  endtask

  task automatic pop_compare();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_result: got row %0d data %0h, expected no result",
               bus.y_row, bus.y_data);
    end else begin
      e = sb.pop_front();
      check("y_row", 64'(bus.y_row), 64'(e.row));
      check("y_data", bus.y_data, e.data);
    end
    last_sat  = sat_bus.y_data;
    last_wrap = wrap_bus.y_data;
  endtask

  task automatic run_case(input vec_t v);
    int cyc, first, last_hs, done_cyc, wait_cnt;
    bit got_done, in_rout;
    logic [15:0] held_row;
    logic [63:0] held_data;
    load_mem(v);
    if (!v.exp_err)
      for (int i = 0; i < int'(v.n_rows); i++) sb.push_back('{row: 16'(i), data: v.exp_y[i]});
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr     = 1'b0;
    num_rows    = v.n_rows;
    bus.y_ready = !v.stall;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; first = -1; last_hs = -1; done_cyc = -1; wait_cnt = 0;
    got_done = 1'b0; in_rout = 1'b0; held_row = '0; held_data = '0;
    while (!got_done && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        got_done = 1'b1;
        done_cyc = cyc;
      end else if (bus.y_valid) begin
        if (first < 0) first = cyc;
        if (in_rout) begin
          check("held_y_row", 64'(bus.y_row), 64'(held_row));
          check("held_y_data", bus.y_data, held_data);
        end else begin
          in_rout   = 1'b1;
          held_row  = bus.y_row;
          held_data = bus.y_data;
          wait_cnt  = 0;
        end
        if (!v.stall || wait_cnt >= 5) begin
          bus.y_ready = 1'b1;
          pop_compare();
          in_rout = 1'b0;
          last_hs = cyc;
        end else begin
          bus.y_ready = 1'b0;
          wait_cnt++;
        end
      end else if (v.stall) begin
        bus.y_ready = 1'b0;
      end
    end
    check("done_seen", 64'(got_done), 64'd1);
    check("err", 64'(err), 64'(v.exp_err));
    check("results_left", 64'(sb.size()), 64'd0);
    if (!v.exp_err) begin
      check("first_latency", 64'(first), 64'(4 + 3 * int'(v.rp[1] - v.rp[0])));
      check("done_after_last_hs", 64'(done_cyc), 64'(last_hs + 1));
    end
    @(posedge clk); #1;
    check("done_one_cycle", 64'(done), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("a_rd_count", 64'(n_a), 64'(v.exp_a));
    check("b_rd_count", 64'(n_b), 64'(v.exp_b));
    sb.delete();
  endtask

  initial begin
    cases[0] = '{n_rows: 16'd2, rp: w4(0, 2, 3, 0), cols: w4(0, 1, 1, 0), vals: w4(2, 3, 4, 0),
                 xv: w4(5, 7, 0, 0), stall: 1'b0, exp_err: 1'b0, exp_y: y3(31, 28, 0),
                 exp_a: 8'd6, exp_b: 8'd6};
    cases[1] = '{n_rows: 16'd2, rp: w4(0, 0, 1, 0), cols: w4(0, 0, 0, 0), vals: w4(-6, 0, 0, 0),
                 xv: w4(9, 0, 0, 0), stall: 1'b0, exp_err: 1'b0, exp_y: y3(0, -54, 0),
                 exp_a: 8'd4, exp_b: 8'd2};
    cases[2] = cases[0];
    cases[2].stall = 1'b1;
    cases[3] = '{n_rows: 16'd1, rp: w4(0, 2, 0, 0), cols: w4(0, 1, 0, 0),
                 vals: w4(1 << 30, 1 << 30, 0, 0), xv: w4(4, 4, 0, 0), stall: 1'b0,
                 exp_err: 1'b0, exp_y: y3(64'sh2_0000_0000, 0, 0), exp_a: 8'd4, exp_b: 8'd4};
    cases[4] = '{n_rows: 16'd1, rp: w4(3, 1, 0, 0), cols: w4(0, 0, 0, 0), vals: w4(0, 0, 0, 0),
                 xv: w4(0, 0, 0, 0), stall: 1'b0, exp_err: 1'b1, exp_y: y3(0, 0, 0),
                 exp_a: 8'd2, exp_b: 8'd0};
    cases[5] = cases[0];
    cases[6] = '{n_rows: 16'd3, rp: w4(0, 1, 1, 3), cols: w4(1, 0, 2, 0), vals: w4(-3, 5, -2, 0),
                 xv: w4(4, -1, 6, 0), stall: 1'b0, exp_err: 1'b0, exp_y: y3(3, 0, 8),
                 exp_a: 8'd7, exp_b: 8'd6};

    rst = 1'b1; start = 1'b0; num_rows = '0; bus.y_ready = 1'b0; cnt_clr = 1'b1;
    last_sat = '0; last_wrap = '0;
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_y_valid", 64'(bus.y_valid), 64'd0);
    check("rst_rd", 64'({bus.a_rd, bus.b_rd}), 64'd0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < NCASES; i++) begin
      run_case(cases[i]);
      if (i == SAT_IDX) begin
        check("sat_clamp", 64'(last_sat), 64'h7fff_ffff);
        check("wrap_mod", 64'(last_wrap), 64'h0);
      end
    end

    // Empty job: done pulses the cycle after start, engine never leaves IDLE.
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0; num_rows = 16'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("zero_rows_done", 64'(done), 64'd1);
    check("zero_rows_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    check("zero_rows_done_drop", 64'(done), 64'd0);
    check("zero_rows_reads", 64'(n_a + n_b), 64'd0);

    // Asynchronous reset in the second NM of row 0, once the accumulator holds 2*5.
    load_mem(cases[0]);
    num_rows = 16'd2; bus.y_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    check("pre_rst_busy", 64'(busy), 64'd1);
    check("pre_rst_acc", bus.y_data, 64'd10);
    rst = 1'b1;
    #1;
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_y_data", bus.y_data, 64'd0);
    check("async_rst_outs", 64'({bus.y_valid, bus.a_rd, bus.b_rd, done, err}), 64'd0);
    check("async_rst_addr", 64'({bus.a_addr, bus.b_addr}), 64'd0);
    @(negedge clk) rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("no_done_after_rst", 64'(done), 64'd0);
    end
    run_case(cases[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_spmv_engine.md
Name: csr_spmv_engine

Overview:
- Parametrised sparse matrix × dense vector engine for CSR data (row pointers, column indices, matrix values, vector values); the successor to the fixed-width fetch control.
- Walks the CSR structure through two read ports and multiply-accumulates each row.
- Emits one result per row over a valid/ready stream.
- Adds configurable widths, a saturation mode, empty-row handling, row-pointer error detection and output backpressure.

Parameters:
- DATA_W, 32, width of matrix/vector elements and index words.
- ADDR_W, 32, memory address width.
- ACC_W, 64, accumulator and result width (must be ≥ DATA_W).
- SAT_EN, 0, 1 = signed saturating accumulate; 0 = wrap modulo 2^ACC_W.
- ROW_W, 16, width of row count and row index.

Ports:
- Clk  in  1  clock.
- Rst  in  1  reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- num_rows  in  ROW_W  row count; sampled on start.
- row_base, col_base, mat_base, vec_base  in  ADDR_W each  CSR array bases; sampled on start.
- a_addr  out  ADDR_W  index port address (row pointers, column indices).
- a_rd  out  1  index port read strobe.
- a_data  in  DATA_W  index port data, valid the cycle after a_rd.
- b_addr  out  ADDR_W  value port address (matrix values, vector values).
- b_rd  out  1  value port read strobe.
- b_data  in  DATA_W  value port data, valid the cycle after b_rd.
- y_valid  out  1  result valid.
- y_ready  in  1  result accepted.
- y_row  out  ROW_W  row index of result.
- y_data  out  ACC_W  signed row dot product.
- busy  out  1  engine active.
- done  out  1  one-cycle pulse at completion.
- err  out  1  sticky row-pointer error; cleared by next accepted start.

Behaviour:
- Reset: single clock; Rst asynchronous, active-high. Clears every output, register and the FSM to IDLE.
- Reset mid-operation: abort immediately; no done pulse.
- Arithmetic: elements signed DATA_W. Product is 2·DATA_W, sign-extended to ACC_W.
- SAT_EN=0: accumulate wraps. SAT_EN=1: clamp to ±(2^(ACC_W-1)) bounds, max 2^(ACC_W-1)-1.
- Address arithmetic is modulo 2^ADDR_W.
- FSM states and transitions:
  - IDLE: start with num_rows=0 → done pulse next cycle, stay IDLE. start otherwise → latch config, r=0, RP0.
  - RP0: a_rd at row_base. → RP0W.
  - RP0W: lo=a_data. → RS.
  - RS: a_rd at row_base+r+1. → RSW.
  - RSW: hi=a_data; k=lo; acc=0. If hi<lo: set err, → DONE. If k==hi: → ROUT. Else → NI.
  - NI: a_rd at col_base+k; b_rd at mat_base+k. → NV.
  - NV: capture col=a_data, m=b_data; b_rd at vec_base+col. → NM.
  - NM: acc += m·b_data; k++. If k==hi → ROUT, else → NI.
  - ROUT: y_valid=1, y_row=r, y_data=acc, held stable until y_ready. On handshake: lo=hi, r++. If r==num_rows → DONE, else → RS.
  - DONE: done=1 for one cycle → IDLE.
- Timing:
  - Per row: 2 cycles overhead, plus 3 cycles per nonzero, plus ≥1 cycle in ROUT.
  - First y_valid occurs 4+3·nnz0 cycles after the start cycle.
- busy = 1 in every state except IDLE.
- start while busy is ignored.
- y_ready high outside ROUT has no effect.
- a_rd and b_rd are single-cycle strobes, low in all states not listed above.

Decomposition:
- Package csr_spmv_pkg holds:
  - state enum;
  - saturation bounds as functions of ACC_W;
  - function sat_add(acc, prod, SAT_EN).
- One sub-module, csr_mac, holds the signed multiply, sign extension and the optionally saturating accumulate register (clear/en inputs).
- The FSM and address generation stay in the top module.

Test Plan:
- Basic: DATA_W=32, num_rows=2, rowptr {0,2,3}, cols {0,1,1}, vals {2,3,4}, x {5,7} → (row0, 31) then (row1, 28); done pulses 1 cycle after the second handshake; err=0.
- Empty row: rowptr {0,0,1}, cols {0}, vals {-6}, x {9} → (row0, 0) with no b_rd for row0, then (row1, -54).
- Backpressure: basic case with y_ready low 5 cycles in each ROUT → y_row/y_data held stable; no extra memory reads; same results.
- Saturation: ACC_W=32, SAT_EN=1, one row with vals {2^30, 2^30}, x {4, 4} → y_data=2^31-1. Same case with SAT_EN=0 → wraps modulo 2^32.
- Error: rowptr {3,1} → err=1, no y_valid, done pulse. Next start with valid data → err cleared, correct results.
- Reset/start edge cases:
  - Rst asserted while in NM → all outputs 0 asynchronously; a following start runs correctly.
  - start with num_rows=0 → done pulse only.
